dispatch_sequencer: RTL

DISPATCH_SEQUENCER -- requirements
Module: dispatch_sequencer

---
 rtl/dispatch_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dispatch_sequencer.sv
// dispatch_sequencer
//   Accepts an 8-instruction fetch bundle, then issues one instruction per
//   cycle to the ALU, load, store or branch unit with a valid/ready handshake.
//   Each instruction gets a tag that is its running instruction number.
//   A branch stalls the sequencer until it is resolved. A taken branch
//   redirects fetch. Finishing the bundle requests the next sequential bundle.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   bundle_valid/ready, _instr, _pc  fetch bundle input (slot k = [32k+31:32k])
//   {alu,ld,st,br}_valid/_ready      per-unit dispatch handshake
//   disp_instr, disp_tag, br_pc      dispatch payload shared by all units
//   br_resolved, br_taken, br_target branch outcome from the branch unit
//   fetch_pc, fetch_req              next bundle address and its update pulse
//   illegal                          pulse when an unknown opcode is skipped
module dispatch_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         bundle_valid,
  input  logic [255:0] bundle_instr,
  input  logic [31:0]  bundle_pc,
  output logic         bundle_ready,
  output logic         alu_valid,
  output logic         ld_valid,
  output logic         st_valid,
  output logic         br_valid,
  input  logic         alu_ready,
  input  logic         ld_ready,
  input  logic         st_ready,
  input  logic         br_ready,
  output logic [31:0]  disp_instr,
  output logic [7:0]   disp_tag,
  output logic [31:0]  br_pc,
  input  logic         br_resolved,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  output logic [31:0]  fetch_pc,
  output logic         fetch_req,
  output logic         illegal
);

  typedef enum logic [1:0] {IDLE, DISPATCH, BRWAIT} state_t;
  typedef enum logic [2:0] {CL_NOP, CL_ALU, CL_LD, CL_ST, CL_BR, CL_ILL} class_t;

  function automatic class_t classify(input logic [31:0] w);
    class_t c;
    c = CL_ILL;
    if (w == 32'h0) begin
      // The all-zero word is a nop even though opcode 000000 is an ALU op.
      c = CL_NOP;
    end else begin
      case (w[31:26])
        6'b000000, 6'b000110, 6'b001000, 6'b001001, 6'b001011,
        6'b001100, 6'b001101, 6'b001110, 6'b001111: c = CL_ALU;
        6'b100011:                                  c = CL_LD;
        6'b101011:                                  c = CL_ST;
        6'b000100, 6'b000101:                       c = CL_BR;
        default:                                    c = CL_ILL;
      endcase
    end
    return c;
  endfunction

  state_t        state_reg, state_next;
  logic [255:0]  bundle_reg;
  logic [31:0]   base_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    tag_reg;
  logic [31:0]   br_pc_reg;
  logic [31:0]   fetch_pc_reg;
  logic          fetch_req_reg;
  logic [31:0]   slot [8];
  class_t        cls;
  logic          accept, handshake, advance, finish, take;

  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    assign slot[gi] = bundle_reg[32*gi +: 32];
  end

  // The payload comes straight from registers, so it cannot change while a
  // unit holds off ready.
  assign disp_instr = slot[idx_reg];
  assign disp_tag   = tag_reg;
  assign br_pc      = br_pc_reg;
  assign fetch_pc   = fetch_pc_reg;
  assign fetch_req  = fetch_req_reg;
  assign cls        = classify(disp_instr);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    bundle_ready = 1'b0;
    alu_valid    = 1'b0;
    ld_valid     = 1'b0;
    st_valid     = 1'b0;
    br_valid     = 1'b0;
    illegal      = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    take         = 1'b0;
    case (state_reg)
      IDLE: begin
        bundle_ready = 1'b1;
        if (bundle_valid) begin
          accept     = 1'b1;
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        alu_valid = (cls == CL_ALU);
        ld_valid  = (cls == CL_LD);
        st_valid  = (cls == CL_ST);
        br_valid  = (cls == CL_BR);
        illegal   = (cls == CL_ILL);
        if (cls == CL_BR) begin
          if (br_ready) state_next = BRWAIT;
        end else if (cls == CL_NOP || cls == CL_ILL ||
                     (alu_valid && alu_ready) || (ld_valid && ld_ready) ||
                     (st_valid && st_ready)) begin
          advance = 1'b1;
        end
      end
      BRWAIT: begin
        if (br_resolved) begin
          if (br_taken) begin
            take       = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = DISPATCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Completing slot 7, by any means, ends the bundle.
    if (advance && idx_reg == 3'd7) state_next = IDLE;
  end

  assign handshake = (alu_valid && alu_ready) || (ld_valid && ld_ready) ||
                     (st_valid && st_ready) || (br_valid && br_ready);
  assign finish    = advance && (idx_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_reg    <= '0;
      base_reg      <= '0;
      idx_reg       <= '0;
      tag_reg       <= '0;
      br_pc_reg     <= '0;
      fetch_pc_reg  <= '0;
      fetch_req_reg <= 1'b0;
    end else begin
      fetch_req_reg <= 1'b0;
      if (accept) begin
        bundle_reg <= bundle_instr;
        base_reg   <= bundle_pc;
        idx_reg    <= 3'd0;
        br_pc_reg  <= bundle_pc;
      end
      if (handshake) tag_reg <= tag_reg + 8'd1;
      if (advance && idx_reg != 3'd7) begin
        idx_reg   <= idx_reg + 3'd1;
        br_pc_reg <= br_pc_reg + 32'd4;
      end
      if (finish) begin
        fetch_pc_reg  <= base_reg + 32'd32;
        fetch_req_reg <= 1'b1;
      end
      if (take) begin
        fetch_pc_reg  <= br_target;
        fetch_req_reg <= 1'b1;
      end
    end
  end

endmodule
